// File: rtl/sensor_regmap_pkg.sv
// Shared types and address-map constants for the sensor snapshot register map.
package sensor_regmap_pkg;

    typedef logic [7:0] byte_t;

    localparam int unsigned STATUS_ADDR = 0;
    localparam int unsigned DATA_BASE   = 1;
    localparam byte_t       OOR_BYTE    = 8'h00;

    // Bytes the map can occupy: status byte, channel data and the checksum slot.
    function automatic int unsigned regmap_bytes(input int unsigned nch, input int unsigned cb);
        return nch * cb + 2;
    endfunction

endpackage

// File: rtl/sensor_chan_reg.sv
// One sensor channel: live register, snapshot bank register and update tracking.
module sensor_chan_reg
    import sensor_regmap_pkg::*;
#(
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] sample_data,
    input  logic          sample_valid,
    input  logic          snap,
    output logic [CW-1:0] bank,
    output logic          fresh,
    output byte_t         live_xor
);

    logic [CW-1:0] live;
    logic          upd;

    always_ff @(posedge clk) begin
        if (rst) begin
            live  <= '0;
            bank  <= '0;
            fresh <= 1'b0;
            upd   <= 1'b0;
        end else begin
            if (sample_valid) begin
                live <= sample_data;
            end
            if (snap) begin
                bank  <= live;
                fresh <= upd | sample_valid;
                // A sample colliding with the capture lands after it, so it also
                // counts toward the following interval.
                upd   <= sample_valid;
            end else if (sample_valid) begin
                upd <= 1'b1;
            end
        end
    end

    always_comb begin
        live_xor = '0;
        for (int unsigned k = 0; k < CW / 8; k++) begin
            live_xor = live_xor ^ live[8*k +: 8];
        end
    end

endmodule

// File: rtl/sensor_snapshot_regmap.sv
// Byte-addressed sensor register map with coherent snapshot bank and 1-cycle read port.
// Define SENSOR_SNAPSHOT_CRC_EN to add an XOR checksum byte at address LAST+1.
module sensor_snapshot_regmap
    import sensor_regmap_pkg::*;
#(
    parameter int unsigned NUM_CH   = 12,
    parameter int unsigned CH_BYTES = 2,
    parameter int unsigned ADDR_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH*8*CH_BYTES-1:0] sample_data,
    input  logic [NUM_CH-1:0]          sample_valid,
    input  logic                       snap_req,
    output logic                       snap_done,
    output logic [7:0]                 snap_seq,
    output logic [NUM_CH-1:0]          fresh,
    input  logic                       rd_en,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic                       rd_valid,
    output logic [7:0]                 rd_data,
    output logic                       rd_err
);

    localparam int unsigned CW   = 8 * CH_BYTES;
    localparam int unsigned LAST = NUM_CH * CH_BYTES;

    if (NUM_CH < 1 || NUM_CH > 64 || CH_BYTES < 1 || CH_BYTES > 4 ||
        64'(regmap_bytes(NUM_CH, CH_BYTES)) > (64'd1 << ADDR_W)) begin : g_cfg_err
        $error("sensor_snapshot_regmap: parameters do not fit the address space");
    end

    logic [CW-1:0] bank [NUM_CH];
    byte_t         live_xor [NUM_CH];
    byte_t         bank_bytes [LAST];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        sensor_chan_reg #(
            .CW(CW)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .sample_data (sample_data[g*CW +: CW]),
            .sample_valid(sample_valid[g]),
            .snap        (snap_req),
            .bank        (bank[g]),
            .fresh       (fresh[g]),
            .live_xor    (live_xor[g])
        );
        // Byte 0 of a channel is its most significant byte.
        for (genvar k = 0; k < CH_BYTES; k++) begin : g_byte
            assign bank_bytes[g*CH_BYTES+k] = bank[g][CW-1-8*k -: 8];
        end
    end

`ifdef SENSOR_SNAPSHOT_CRC_EN
    byte_t chk;
    byte_t live_xor_all;

    always_comb begin
        live_xor_all = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            live_xor_all = live_xor_all ^ live_xor[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chk <= '0;
        end else if (snap_req) begin
            chk <= live_xor_all;
        end
    end
`else
    logic unused_live_xor;

    always_comb begin
        unused_live_xor = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            unused_live_xor = unused_live_xor ^ (^live_xor[i]);
        end
    end
`endif

    byte_t rd_byte;
    logic  rd_oor;

    always_comb begin
        rd_byte = OOR_BYTE;
        rd_oor  = 1'b1;
        if (32'(rd_addr) == STATUS_ADDR) begin
            rd_byte = snap_seq;
            rd_oor  = 1'b0;
        end
        for (int unsigned j = 0; j < LAST; j++) begin
            if (32'(rd_addr) == DATA_BASE + j) begin
                rd_byte = bank_bytes[j];
                rd_oor  = 1'b0;
            end
        end
`ifdef SENSOR_SNAPSHOT_CRC_EN
        if (32'(rd_addr) == DATA_BASE + LAST) begin
            rd_byte = chk;
            rd_oor  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_seq  <= '0;
            snap_done <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_err    <= 1'b0;
        end else begin
            snap_done <= snap_req;
            if (snap_req) begin
                snap_seq <= snap_seq + 8'd1;
            end
            rd_valid <= rd_en;
            rd_err   <= rd_en & rd_oor;
            if (rd_en) begin
                rd_data <= rd_byte;
            end
        end
    end

endmodule

// File: tb/tb_sensor_snapshot_regmap.sv
// Self-checking bench for sensor_snapshot_regmap: read scoreboard plus snapshot sequences.
module tb_sensor_snapshot_regmap;

    localparam int NUM_CH   = 12;
    localparam int CH_BYTES = 2;
    localparam int ADDR_W   = 8;
    localparam int CW       = 8 * CH_BYTES;

    logic                   clk;
    logic                   rst;
    logic [NUM_CH*CW-1:0]   sample_data;
    logic [NUM_CH-1:0]      sample_valid;
    logic                   snap_req;
    logic                   snap_done;
    logic [7:0]             snap_seq;
    logic [NUM_CH-1:0]      fresh;
    logic                   rd_en;
    logic [ADDR_W-1:0]      rd_addr;
    logic                   rd_valid;
    logic [7:0]             rd_data;
    logic                   rd_err;

    sensor_snapshot_regmap #(
        .NUM_CH  (NUM_CH),
        .CH_BYTES(CH_BYTES),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_data (sample_data),
        .sample_valid(sample_valid),
        .snap_req    (snap_req),
        .snap_done   (snap_done),
        .snap_seq    (snap_seq),
        .fresh       (fresh),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_err      (rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       err;
    } vec_t;

    vec_t sbq[$];
    vec_t tbl[27];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic monitor();
        vec_t e;
        if (rd_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                check("rd_valid_unexpected", 32'(rd_valid), 32'd0);
            end else begin
                e = sbq.pop_front();
                check($sformatf("rd_data@%0d", e.addr), 32'(rd_data), 32'(e.data));
                check($sformatf("rd_err@%0d", e.addr), 32'(rd_err), 32'(e.err));
            end
        end else if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check($sformatf("rd_valid@%0d", e.addr), 32'(rd_valid), 32'd1);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
    endtask

    task automatic cycle();
        tick();
        sample_valid = '0;
        snap_req     = 1'b0;
        rd_en        = 1'b0;
    endtask

    task automatic issue_read(input logic [7:0] addr, input logic [7:0] data, input logic err);
        vec_t e;
        e.addr  = addr;
        e.data  = data;
        e.err   = err;
        rd_en   = 1'b1;
        rd_addr = addr;
        sbq.push_back(e);
    endtask

    task automatic read(input logic [7:0] addr, input logic [7:0] data, input logic err);
        issue_read(addr, data, err);
        cycle();
    endtask

    task automatic load(input int ch, input logic [CW-1:0] val);
        sample_valid[ch]        = 1'b1;
        sample_data[ch*CW +: CW] = val;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [3:0] nib;
        rst          = 1'b1;
        sample_data  = '0;
        sample_valid = '0;
        snap_req     = 1'b0;
        rd_en        = 1'b1;
        rd_addr      = '0;

        // Reads during reset are dropped.
        repeat (2) begin
            tick();
            check("rd_valid_in_reset", 32'(rd_valid), 32'd0);
        end
        rst   = 1'b0;
        rd_en = 1'b0;
        cycle();
        check("reset_snap_seq", 32'(snap_seq), 32'd0);
        check("reset_fresh", 32'(fresh), 32'd0);
        check("reset_snap_done", 32'(snap_done), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'd0);
        check("reset_rd_err", 32'(rd_err), 32'd0);
        for (int a = 0; a <= 24; a++) read(8'(a), 8'h00, 1'b0);

        // Coherency: bank keeps the captured value after live moves on.
        load(0, 16'hA55A);
        cycle();
        snap_req = 1'b1;
        cycle();
        check("snap_done_pulse", 32'(snap_done), 32'd1);
        load(0, 16'h1234);
        cycle();
        check("snap_done_cleared", 32'(snap_done), 32'd0);
        read(8'd1, 8'hA5, 1'b0);
        read(8'd2, 8'h5A, 1'b0);
        read(8'd0, 8'h01, 1'b0);
        check("coh_snap_seq", 32'(snap_seq), 32'd1);
        check("coh_fresh", 32'(fresh), 32'h001);

        // Collision: bank gets the old ch3 value, live the new one.
        load(3, 16'h0001);
        cycle();
        load(3, 16'h00FF);
        snap_req = 1'b1;
        cycle();
        check("col_fresh1", 32'(fresh), 32'h009);
        read(8'd7, 8'h00, 1'b0);
        read(8'd8, 8'h01, 1'b0);
        snap_req = 1'b1;
        cycle();
        check("col_fresh2", 32'(fresh), 32'h008);
        read(8'd7, 8'h00, 1'b0);
        read(8'd8, 8'hFF, 1'b0);
        read(8'd1, 8'h12, 1'b0);
        read(8'd2, 8'h34, 1'b0);

        // Range limits.
`ifdef SENSOR_SNAPSHOT_CRC_EN
        read(8'd25, 8'hD9, 1'b0);
`else
        read(8'd25, 8'h00, 1'b1);
`endif
        read(8'hFF, 8'h00, 1'b1);
        read(8'd24, 8'h00, 1'b0);

        // Table-driven reads of a full-bank pattern, issued back to back.
        for (int i = 0; i < NUM_CH; i++) begin
            nib = 4'(i);
            load(i, {8'hC0, nib, nib});
        end
        cycle();
        snap_req = 1'b1;
        cycle();
        tbl[0] = '{addr: 8'd0, data: 8'h04, err: 1'b0};
        for (int i = 0; i < NUM_CH; i++) begin
            nib = 4'(i);
            tbl[2*i+1] = '{addr: 8'(2*i+1), data: 8'hC0, err: 1'b0};
            tbl[2*i+2] = '{addr: 8'(2*i+2), data: {nib, nib}, err: 1'b0};
        end
`ifdef SENSOR_SNAPSHOT_CRC_EN
        tbl[25] = '{addr: 8'd25, data: 8'h00, err: 1'b0};
`else
        tbl[25] = '{addr: 8'd25, data: 8'h00, err: 1'b1};
`endif
        tbl[26] = '{addr: 8'hFF, data: 8'h00, err: 1'b1};
        for (int i = 0; i < 27; i++) begin
            issue_read(tbl[i].addr, tbl[i].data, tbl[i].err);
            cycle();
        end

        // Four-cycle burst keeps snap_done high throughout.
        snap_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("burst_snap_done%0d", i), 32'(snap_done), 32'd1);
        end
        snap_req = 1'b0;
        tick();
        check("burst_snap_done_end", 32'(snap_done), 32'd0);
        check("burst_snap_seq", 32'(snap_seq), 32'd8);

        // Sequence counter wrap.
        snap_req = 1'b1;
        repeat (247) tick();
        check("seq_ff", 32'(snap_seq), 32'hFF);
        tick();
        snap_req = 1'b0;
        tick();
        check("seq_wrap", 32'(snap_seq), 32'd0);
        read(8'd0, 8'h00, 1'b0);

        // Read coincident with a snapshot returns the pre-snapshot bank.
        load(1, 16'h0102);
        cycle();
        snap_req = 1'b1;
        cycle();
        load(1, 16'h0304);
        cycle();
        issue_read(8'd3, 8'h01, 1'b0);
        snap_req = 1'b1;
        cycle();
        read(8'd3, 8'h03, 1'b0);

        check("sb_drain", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
